// File: rtl/sram_128x8_ctrl.sv
// Request/response controller for a 128x8 single-port SRAM macro with a registered read port.
// It fills the array with INIT_VAL after reset or on request, then serves posted writes and buffered reads.
module sram_128x8_ctrl #(
  parameter int                ADDR_W   = 7,
  parameter int                DATA_W   = 8,
  parameter int                DEPTH    = 128,
  parameter logic [DATA_W-1:0] INIT_VAL = {DATA_W{1'b0}}
) (
  input  logic              CLK,
  input  logic              RSTB,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  input  logic              init_req,
  output logic              init_done,
  output logic              CEB,
  output logic              WEB,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] D,
  input  logic [DATA_W-1:0] Q
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                rd_pend_q, rd_pend_d;
  logic                hold_v_q, hold_v_d;
  logic [DATA_W-1:0]   hold_d_q, hold_d_d;
  logic                init_pend_q, init_pend_d;
  logic                stall_s;
  logic                accept_s;

  // A read response that is not taken this cycle blocks new requests.
  assign stall_s    = rd_pend_q & ~resp_ready;
  assign req_ready  = (state_q == ST_RUN) & ~init_pend_q & ~hold_v_q & ~stall_s;
  assign accept_s   = req_valid & req_ready;
  assign init_done  = (state_q == ST_RUN);
  assign resp_valid = hold_v_q | rd_pend_q;

  // Response data mux: the hold buffer has priority over the live macro output.
  always_comb begin
    resp_rdata = {DATA_W{1'b0}};
    if (hold_v_q) begin
      resp_rdata = hold_d_q;
    end else if (rd_pend_q) begin
      resp_rdata = Q;
    end else begin
      resp_rdata = {DATA_W{1'b0}};
    end
  end

  // Macro strobes: fill writes in INIT, accepted requests in RUN, idle otherwise.
  always_comb begin
    CEB = 1'b1;
    WEB = 1'b1;
    A   = {ADDR_W{1'b0}};
    D   = {DATA_W{1'b0}};
    case (state_q)
      ST_INIT: begin
        CEB = 1'b0;
        WEB = 1'b0;
        A   = cnt_q;
        D   = INIT_VAL;
      end
      ST_RUN: begin
        if (accept_s) begin
          CEB = 1'b0;
          WEB = ~req_write;
          A   = req_addr;
          D   = req_write ? req_wdata : {DATA_W{1'b0}};
        end else begin
          CEB = 1'b1;
          WEB = 1'b1;
        end
      end
      default: begin
        CEB = 1'b1;
        WEB = 1'b1;
      end
    endcase
  end

  // Sequencing between boot, fill and normal traffic, including deferred refill.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_pend_d = init_pend_q;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_INIT;
        cnt_d   = {ADDR_W{1'b0}};
      end
      ST_INIT: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_RUN: begin
        // Refill waits until no read data is outstanding, so no response is lost.
        if (init_pend_q && !rd_pend_q && !hold_v_q) begin
          state_d     = ST_INIT;
          cnt_d       = {ADDR_W{1'b0}};
          init_pend_d = 1'b0;
        end else if (init_req) begin
          init_pend_d = 1'b1;
        end else begin
          init_pend_d = init_pend_q;
        end
      end
      default: begin
        state_d     = ST_BOOT;
        cnt_d       = {ADDR_W{1'b0}};
        init_pend_d = 1'b0;
      end
    endcase
  end

  // Read tracking and the one-entry hold buffer; Q is only valid the cycle after a read.
  always_comb begin
    rd_pend_d = accept_s & ~req_write;
    hold_v_d  = hold_v_q;
    hold_d_d  = hold_d_q;
    if (stall_s) begin
      hold_v_d = 1'b1;
      hold_d_d = Q;
    end else if (hold_v_q && resp_ready) begin
      hold_v_d = 1'b0;
    end else begin
      hold_v_d = hold_v_q;
    end
  end

  // State registers.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q     <= ST_BOOT;
      cnt_q       <= {ADDR_W{1'b0}};
      rd_pend_q   <= 1'b0;
      hold_v_q    <= 1'b0;
      hold_d_q    <= {DATA_W{1'b0}};
      init_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_pend_q   <= rd_pend_d;
      hold_v_q    <= hold_v_d;
      hold_d_q    <= hold_d_d;
      init_pend_q <= init_pend_d;
    end
  end

endmodule

// File: tb/tb_sram_128x8_ctrl.sv
// Self-checking bench: behavioural SRAM macro, reference memory with a response scoreboard,
// a vector table for basic traffic and hand-written sequences for fill, backpressure, refill and reset.
module tb_sram_128x8_ctrl;

  localparam logic [7:0] IV = 8'h3C;

  logic       CLK, RSTB;
  logic       req_valid, req_ready, req_write;
  logic [6:0] req_addr;
  logic [7:0] req_wdata;
  logic       resp_valid, resp_ready;
  logic [7:0] resp_rdata;
  logic       init_req, init_done;
  logic       CEB, WEB;
  logic [6:0] A;
  logic [7:0] D;
  logic [7:0] Q;

  int checks = 0;
  int errors = 0;
  int fill_gen = 0;
  int last_gen = 0;

  logic [7:0] mem_m   [128];
  logic [7:0] ref_mem [128];
  logic [7:0] sb_q [$];

  typedef struct {
    logic       vld;
    logic       wr;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       exp_rv;
    logic [7:0] exp_rd;
  } vec_t;
  vec_t tbl [21];

  sram_128x8_ctrl #(.ADDR_W(7), .DATA_W(8), .DEPTH(128), .INIT_VAL(IV)) dut (
    .CLK(CLK), .RSTB(RSTB),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .init_req(init_req), .init_done(init_done),
    .CEB(CEB), .WEB(WEB), .A(A), .D(D), .Q(Q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Macro model: registered read port, random Q in any cycle not following a read.
  always @(posedge CLK) begin
    if (!CEB && WEB) Q <= mem_m[A];
    else             Q <= 8'($urandom);
    if (!CEB && !WEB) mem_m[A] <= D;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: push reference data on accepted reads, pop on response handshakes.
  always @(negedge CLK) begin
    if (!RSTB) begin
      sb_q.delete();
    end else begin
      if (fill_gen != last_gen) begin
        for (int i = 0; i < 128; i++) ref_mem[i] = IV;
        last_gen = fill_gen;
      end
      if (req_valid && req_ready) begin
        if (req_write) ref_mem[req_addr] = req_wdata;
        else           sb_q.push_back(ref_mem[req_addr]);
      end
      if (resp_valid && resp_ready) begin
        if (sb_q.size() == 0) chk("sb_unexpected_resp", 32'd1, 32'd0);
        else                  chk("sb_data", {24'd0, resp_rdata}, {24'd0, sb_q.pop_front()});
      end
      if (!resp_valid) chk("rdata_zero_idle", {24'd0, resp_rdata}, 32'd0);
    end
  end

  task automatic drive(input logic v, input logic w, input logic [6:0] a, input logic [7:0] d,
                       input logic rr, input logic ir);
    @(posedge CLK);
    #1;
    req_valid = v; req_write = w; req_addr = a; req_wdata = d;
    resp_ready = rr; init_req = ir;
  endtask

  task automatic chk_reset_outs(input string name);
    chk(name, {4'd0, req_ready, resp_valid, resp_rdata, init_done, CEB, WEB, A, D},
              {4'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 7'h00, 8'h00});
  endtask

  task automatic chk_fill(input int k);
    chk("fill_strobe", {6'd0, CEB, WEB, A, D, req_ready, init_done, 8'd0},
                       {6'd0, 1'b0, 1'b0, 7'(k), IV, 1'b0, 1'b0, 8'd0});
  endtask

  // Reset, release, and follow the fill; abort_at >= 0 re-asserts reset at that fill address.
  task automatic reset_fill(input int abort_at);
    RSTB = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 7'h00; req_wdata = 8'h00;
    resp_ready = 1'b1; init_req = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RSTB = 1'b1;
    @(negedge CLK);
    chk_reset_outs("boot_cycle");
    for (int k = 0; k < 128; k++) begin
      @(negedge CLK);
      chk_fill(k);
      if (k == abort_at) begin
        #1 RSTB = 1'b0;
        #1 chk_reset_outs("reset_mid_init");
        return;
      end
    end
    @(negedge CLK);
    chk("run_after_fill", {29'd0, init_done, req_ready, CEB}, {29'd0, 1'b1, 1'b1, 1'b1});
    fill_gen++;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    RSTB = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 7'h00; req_wdata = 8'h00;
    resp_ready = 1'b1; init_req = 1'b0;

    // Vector table: per cycle inputs and the response expected in that same cycle.
    tbl[0] = '{1'b1, 1'b0, 7'h55, 8'h00, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 1'b1, 7'h12, 8'hA5, 1'b1, IV};
    tbl[2] = '{1'b1, 1'b0, 7'h12, 8'h00, 1'b0, 8'h00};
    tbl[3] = '{1'b1, 1'b1, 7'h00, 8'h00, 1'b1, 8'hA5};
    for (int i = 1; i < 8; i++) tbl[3+i] = '{1'b1, 1'b1, 7'(i), 8'(i), 1'b0, 8'h00};
    for (int i = 0; i < 8; i++)
      tbl[11+i] = '{1'b1, 1'b0, 7'(i), 8'h00, (i != 0), (i != 0) ? 8'(i-1) : 8'h00};
    tbl[19] = '{1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 8'h07};
    tbl[20] = '{1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 8'h00};

    #1 chk_reset_outs("reset_state");
    reset_fill(-1);

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].vld, tbl[i].wr, tbl[i].addr, tbl[i].wdata, 1'b1, 1'b0);
      @(negedge CLK);
      chk("tbl_req_ready", {31'd0, req_ready}, 32'd1);
      chk("tbl_resp", {23'd0, resp_valid, resp_rdata}, {23'd0, tbl[i].exp_rv, tbl[i].exp_rd});
    end

    // Backpressure: three stalled cycles, then one handshake.
    drive(1'b1, 1'b0, 7'h12, 8'h00, 1'b1, 1'b0);
    @(negedge CLK);
    chk("bp_accept_ready", {31'd0, req_ready}, 32'd1);
    for (int j = 0; j < 3; j++) begin
      drive(1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 1'b0);
      @(negedge CLK);
      chk("bp_stall", {22'd0, resp_valid, resp_rdata, req_ready}, {22'd0, 1'b1, 8'hA5, 1'b0});
    end
    drive(1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 1'b0);
    @(negedge CLK);
    chk("bp_handshake", {22'd0, resp_valid, resp_rdata, req_ready}, {22'd0, 1'b1, 8'hA5, 1'b0});
    drive(1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 1'b0);
    @(negedge CLK);
    chk("bp_after", {30'd0, resp_valid, req_ready}, {30'd0, 1'b0, 1'b1});
    chk("bp_one_response", sb_q.size(), 32'd0);

    // Refill requested while a read response is stalled.
    drive(1'b1, 1'b0, 7'h12, 8'h00, 1'b1, 1'b0);
    @(negedge CLK);
    chk("rf_accept", {31'd0, req_ready}, 32'd1);
    drive(1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 1'b1);
    @(negedge CLK);
    chk("rf_stall1", {22'd0, resp_valid, resp_rdata, req_ready}, {22'd0, 1'b1, 8'hA5, 1'b0});
    drive(1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 1'b0);
    @(negedge CLK);
    chk("rf_stall2", {22'd0, resp_valid, resp_rdata, req_ready}, {22'd0, 1'b1, 8'hA5, 1'b0});
    drive(1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 1'b0);
    @(negedge CLK);
    chk("rf_handshake", {22'd0, resp_valid, resp_rdata, req_ready}, {22'd0, 1'b1, 8'hA5, 1'b0});
    drive(1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 1'b0);
    @(negedge CLK);
    chk("rf_cleared", {28'd0, resp_valid, req_ready, init_done, CEB}, {28'd0, 1'b0, 1'b0, 1'b1, 1'b1});
    for (int k = 0; k < 128; k++) begin
      @(negedge CLK);
      chk_fill(k);
    end
    @(negedge CLK);
    chk("rf_run", {30'd0, init_done, req_ready}, {30'd0, 1'b1, 1'b1});
    fill_gen++;
    drive(1'b1, 1'b0, 7'h12, 8'h00, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 7'h40, 8'h00, 1'b1, 1'b0);
    @(negedge CLK);
    chk("rf_read_12", {23'd0, resp_valid, resp_rdata}, {23'd0, 1'b1, IV});
    drive(1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 1'b0);
    @(negedge CLK);
    chk("rf_read_40", {23'd0, resp_valid, resp_rdata}, {23'd0, 1'b1, IV});

    // Reset at fill address 60, then a complete fill from address 0.
    reset_fill(60);
    reset_fill(-1);

    // Reset while a response sits in the hold buffer.
    drive(1'b1, 1'b1, 7'h21, 8'h5A, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 7'h21, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 1'b0);
    @(negedge CLK);
    chk("hold_before_reset", {23'd0, resp_valid, resp_rdata}, {23'd0, 1'b1, 8'h5A});
    #1 RSTB = 1'b0;
    #1 chk_reset_outs("reset_mid_read");
    reset_fill(-1);
    for (int j = 0; j < 4; j++) begin
      drive(1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 1'b0);
      @(negedge CLK);
      chk("no_stale_resp", {31'd0, resp_valid}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_128x8_ctrl.md
# sram_128x8_ctrl

Initiator-side controller for a 128x8 single-port SRAM macro with active-low chip enable (CEB), active-low write enable (WEB) and a registered read port (Q valid one cycle after a read, undefined otherwise). It converts a valid/ready request stream into macro strobes and returns read data through a backpressurable response port with a one-entry hold buffer. After reset, and on demand, it fills the whole array with a known value before accepting traffic.

## Interface
- ADDR_W, 7: address width.
- DATA_W, 8: data width.
- DEPTH, 128: word count, equal to 2**ADDR_W.
- INIT_VAL, 0: fill value written during INIT.
- CLK  in  1  clock; macro shares it.
- RSTB  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  read data available.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  DATA_W  read data; 0 when resp_valid = 0.
- init_req  in  1  pulse; request a refill of the array with INIT_VAL.
- init_done  out  1  high in RUN.
- CEB  out  1  macro chip enable, active low.
- WEB  out  1  macro write enable, active low.
- A  out  ADDR_W  macro address.
- D  out  DATA_W  macro write data.
- Q  in  DATA_W  macro read data.

## Operation
- States: BOOT (reset state), INIT, RUN.
  - BOOT goes to INIT after 1 cycle.
  - INIT writes INIT_VAL to addresses 0..DEPTH-1 using cnt. It drives CEB=0, WEB=0, A=cnt, D=INIT_VAL.
  - INIT goes to RUN after the cycle with cnt = DEPTH-1.
- Macro outputs are combinational from state and the accepted request.
- Outside INIT, when no request is accepted, the idle drive is CEB=1, WEB=1, A=0, D=0.
- In RUN, when a request is accepted:
  - CEB=0, WEB=!req_write, A=req_addr, D=req_wdata (D=0 for reads).
- Writes are posted and produce no response.
- Internal registers:
  - rd_pend: set for the cycle after an accepted read. Q is valid only in that cycle.
  - hold_v / hold_d: one-entry response buffer.
  - init_pend: init_req latched in RUN.
- resp_valid = hold_v | rd_pend.
- resp_rdata = hold_v ? hold_d : (rd_pend ? Q : 0).
- hold_v and rd_pend are never both 1.
- Hold buffer rules:
  - rd_pend && !resp_ready: capture hold_d <= Q, hold_v <= 1. Q is never sampled again.
  - hold_v && resp_ready: hold_v <= 0.
- req_ready = (state==RUN) && !init_pend && !hold_v && !(rd_pend && !resp_ready). It depends combinationally on resp_ready.
- Refill:
  - init_req in RUN sets init_pend.
  - When init_pend && !rd_pend && !hold_v, go to INIT with cnt=0 and clear init_pend.
  - init_req in BOOT or INIT is ignored.
- init_done = (state==RUN).
- Reset values: state BOOT, cnt 0, rd_pend 0, hold_v 0, hold_d 0, init_pend 0. Resulting outputs: req_ready 0, resp_valid 0, resp_rdata 0, init_done 0, CEB 1, WEB 1, A 0, D 0.
- Reset mid-operation (any state) aborts everything: an in-flight read is dropped, a buffered response is lost, and the fill restarts from address 0.

## Timing
- After RSTB rises:
  - Cycle 0: BOOT.
  - Cycles 1..128: INIT writes addresses 0..127.
  - Cycle 129: RUN, init_done=1; req_ready=1 if no refill is pending.
- Read latency: read accepted in cycle t, resp_valid=1 in cycle t+1 with data from Q.
- With resp_ready held high, one read per cycle is sustained; back-to-back reads give back-to-back responses.
- A write at cycle t followed by a read of the same address at t+1 returns the new data at t+2.
- With resp_ready low at t+1, the data is held from t+2 until the handshake completes, and req_ready stays 0 until then.
- Refill request with a read pending: INIT starts in the first cycle after the response clears. It takes 128 cycles, then 1 cycle to RUN.

## Test plan
- Post-reset fill:
  - Stimulus: release RSTB with INIT_VAL=0x00.
  - Required: exactly 128 write strobes to addresses 0..127 in cycles 1..128; init_done=1 and req_ready=1 at cycle 129; a read of address 0x55 returns 0x00.
- Write then read:
  - Stimulus: write 0xA5 to 0x12 at t, read 0x12 at t+1, resp_ready=1.
  - Required: resp_valid=1 and resp_rdata=0xA5 at t+2; resp_rdata=0 otherwise.
- Backpressure:
  - Stimulus: read 0x12 (holding 0xA5) with resp_ready=0 for 3 cycles, then 1; the macro model drives random Q after the read cycle.
  - Required: resp_rdata stays 0xA5 throughout; req_ready=0 until the handshake; exactly one response.
- Streaming:
  - Stimulus: write 0..7 to addresses 0..7, then 8 back-to-back reads with resp_ready=1.
  - Required: 8 consecutive responses carrying 0..7 in order, with no bubbles.
- Refill during traffic:
  - Stimulus: pulse init_req (INIT_VAL=0x3C) while a read response is stalled, then release resp_ready.
  - Required: INIT starts the cycle after the response clears; req_ready=0 for 128 cycles; reads afterwards return 0x3C.
- Reset mid-INIT and mid-read:
  - Stimulus: assert RSTB low at fill address 60, and separately with hold_v=1.
  - Required: all outputs return to their reset values immediately; the fill restarts from address 0; no stale response appears.
